// File: rtl/demod_pkg.sv
// Shared types and constants for the demodulation segment serializer.
// Frame geometry defaults and the serializer FSM encoding live here.
package demod_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam int SEG_WIDTH = 32;
  localparam int NUM_SEG   = 10;
  localparam int FCNT_W    = 16;
  localparam int IDX_W     = 4;

endpackage

// File: rtl/demodulation_segment_serializer_if.sv
// Downstream segment stream: valid/ready handshake carrying data, index and last.
// The serializer drives through the master modport, the consumer uses slave.
interface demodulation_segment_serializer_if #(
  parameter int WIDTH = demod_pkg::SEG_WIDTH
) ();

  logic                          out_valid;
  logic                          out_ready;
  logic [WIDTH-1:0]              out_data;
  logic [demod_pkg::IDX_W-1:0]   out_index;
  logic                          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/demod_segment_bank.sv
// Segment register file: parallel load of a whole frame, indexed read port and
// a combinational XOR-reduce of the stored frame.
module demod_segment_bank
  import demod_pkg::IDX_W;
#(
  parameter int NUM_SEG = demod_pkg::NUM_SEG,
  parameter int WIDTH   = demod_pkg::SEG_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [NUM_SEG*WIDTH-1:0] seg_in,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         xor_out
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

  logic [WIDTH-1:0] bank [NUM_SEG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SEG; i++) bank[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_SEG; i++) bank[i] <= seg_in[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    xor_out = '0;
    for (int i = 0; i < NUM_SEG; i++) xor_out = xor_out ^ bank[i];
  end

  // The index never leaves 0..NUM_SEG-1; the guard keeps the read total.
  always_comb begin
    rd_data = '0;
    if (rd_idx <= LAST_IDX) rd_data = bank[rd_idx];
  end

endmodule

// File: rtl/demodulation_segment_serializer.sv
// Requests a frame from the upstream demodulation block, captures all segments
// at once and streams them out one per accept with index, last flag and XOR.
module demodulation_segment_serializer
  import demod_pkg::state_t, demod_pkg::IDLE, demod_pkg::REQUEST, demod_pkg::DRAIN,
         demod_pkg::FCNT_W, demod_pkg::IDX_W;
#(
  parameter int NUM_SEG = demod_pkg::NUM_SEG,
  parameter int WIDTH   = demod_pkg::SEG_WIDTH,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  output logic                      up_start,
  input  logic                      up_valid,
  input  logic [NUM_SEG*WIDTH-1:0]  segments_in,
  demodulation_segment_serializer_if.master out_if,
  output logic [WIDTH-1:0]          frame_xor,
  output logic [FCNT_W-1:0]         frame_count,
  output logic                      busy,
  output logic                      err
);

  localparam int               TCNT_W   = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

  state_t              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                up_start_q, up_start_d;
  logic                err_q, err_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic                load;
  logic                accept;

  assign accept = (state_q == DRAIN) && out_if.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tcnt_q     <= '0;
      idx_q      <= '0;
      up_start_q <= 1'b0;
      err_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
      up_start_q <= up_start_d;
      err_q      <= err_d;
      fcnt_q     <= fcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    idx_d      = idx_q;
    up_start_d = up_start_q;
    err_d      = err_q;
    fcnt_d     = fcnt_q;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d    = REQUEST;
          up_start_d = 1'b1;
          tcnt_d     = '0;
        end
      end
      REQUEST: begin
        if (up_valid) begin
          load       = 1'b1;
          up_start_d = 1'b0;
          idx_d      = '0;
          state_d    = DRAIN;
        end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          up_start_d = 1'b0;
          state_d    = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            fcnt_d = fcnt_q + 1'b1;
            idx_d  = '0;
            // Chain straight into the next request so the period stays minimal.
            if (run) begin
              state_d    = REQUEST;
              up_start_d = 1'b1;
              tcnt_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  demod_segment_bank #(
    .NUM_SEG (NUM_SEG),
    .WIDTH   (WIDTH)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .seg_in  (segments_in),
    .rd_idx  (idx_q),
    .rd_data (out_if.out_data),
    .xor_out (frame_xor)
  );

  assign out_if.out_valid = (state_q == DRAIN);
  assign out_if.out_index = idx_q;
  assign out_if.out_last  = (state_q == DRAIN) && (idx_q == LAST_IDX);
  assign up_start         = up_start_q;
  assign frame_count      = fcnt_q;
  assign busy             = (state_q != IDLE);
  assign err              = err_q;

endmodule
